// File: rtl/shift_sequencer_pkg.sv
// Shared types for the shift sequencer:
// FSM states, op codes and default widths.
package shift_sequencer_pkg;

  localparam int SEQ_WIDTH = 16;
  localparam int SEQ_CNT_W = 4;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    OP_NONE = 2'b00,
    OP_LSL  = 2'b01,
    OP_LSR  = 2'b10,
    OP_ASR  = 2'b11
  } op_t;

endpackage

// File: rtl/shift_sequencer_shifter.sv
// Single-bit shifter step: LSL, LSR (zero fill)
// or ASR (sign fill); bits shifted out are lost.
module shift_sequencer_shifter
  import shift_sequencer_pkg::*;
#(
  parameter int WIDTH = SEQ_WIDTH
) (
  input  logic [WIDTH-1:0] i_in,
  input  op_t              i_shift,
  output logic [WIDTH-1:0] o_sout
);

  always_comb begin
    o_sout = i_in;
    unique case (i_shift)
      OP_NONE: o_sout = i_in;
      OP_LSL:  o_sout = {i_in[WIDTH-2:0], 1'b0};
      OP_LSR:  o_sout = {1'b0, i_in[WIDTH-1:1]};
      OP_ASR:  o_sout = {i_in[WIDTH-1], i_in[WIDTH-1:1]};
    endcase
  end

endmodule

// File: rtl/shift_sequencer.sv
// Multi-cycle shift-by-N controller: loads the operand once,
// then steps the single-bit shifter once per clock.
module shift_sequencer
  import shift_sequencer_pkg::*;
#(
  parameter int WIDTH = SEQ_WIDTH,
  parameter int CNT_W = SEQ_CNT_W
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_start,
  input  logic [WIDTH-1:0] i_in_val,
  input  logic [1:0]       i_op,
  input  logic [CNT_W-1:0] i_count,
  output logic             o_busy,
  output logic             o_done,
  output logic [WIDTH-1:0] o_result
);

  state_t           r_state;
  state_t           w_next;
  logic [WIDTH-1:0] r_acc;
  logic [CNT_W-1:0] r_rem;
  op_t              r_op;

  logic [WIDTH-1:0] w_sout;
  logic [CNT_W-1:0] w_n;
  logic             w_accept;

  assign w_n = (op_t'(i_op) == OP_NONE) ? '0 : i_count;

  assign w_accept = i_start &&
                    (r_state == S_IDLE || r_state == S_DONE);

  assign o_result = r_acc;

  shift_sequencer_shifter #(
    .WIDTH (WIDTH)
  ) u_shifter (
    .i_in    (r_acc),
    .i_shift (r_op),
    .o_sout  (w_sout)
  );

  always_comb begin
    w_next = S_IDLE;
    o_busy = 1'b0;
    o_done = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_accept)
          w_next = (w_n == '0) ? S_DONE : S_SHIFT;
      end
      S_SHIFT: begin
        o_busy = 1'b1;
        w_next = (r_rem <= CNT_W'(1)) ? S_DONE : S_SHIFT;
      end
      S_DONE: begin
        o_done = 1'b1;
        if (w_accept)
          w_next = (w_n == '0) ? S_DONE : S_SHIFT;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= S_IDLE;
      r_acc   <= '0;
      r_rem   <= '0;
      r_op    <= OP_NONE;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_acc <= i_in_val;
        r_op  <= op_t'(i_op);
        r_rem <= w_n;
      end else if (r_state == S_SHIFT) begin
        r_acc <= w_sout;
        r_rem <= r_rem - CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_shift_sequencer.sv
// Bench for shift_sequencer: directed vector table, multi-cycle
// corner sequences and random ops against a reference model.
module tb_shift_sequencer;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [15:0] in_val = '0;
  logic [1:0]  op = '0;
  logic [3:0]  count = '0;
  logic        busy;
  logic        done;
  logic [15:0] result;

  int n_checks = 0;
  int n_fail = 0;

  logic [15:0] sb_q[$];
  logic [15:0] last_exp;

  typedef struct {
    logic [1:0]  op;
    logic [3:0]  cnt;
    logic [15:0] val;
    logic [15:0] exp;
    string       nm;
  } vec_t;

  vec_t vecs[10];

  shift_sequencer dut (
    .i_clk    (clk),
    .i_reset  (reset),
    .i_start  (start),
    .i_in_val (in_val),
    .i_op     (op),
    .i_count  (count),
    .o_busy   (busy),
    .o_done   (done),
    .o_result (result)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: sim time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h",
               nm, got, exp);
    end
  endtask

  function automatic int eff_n(input logic [1:0] o,
                               input logic [3:0] c);
    return (o == 2'b00) ? 0 : int'(c);
  endfunction

  function automatic logic [15:0] model(
      input logic [1:0]  o,
      input logic [3:0]  c,
      input logic [15:0] v);
    int n;
    logic [15:0] r;
    n = eff_n(o, c);
    case (o)
      2'b01:   r = v << n;
      2'b10:   r = v >> n;
      2'b11:   r = 16'($signed(v) >>> n);
      default: r = v;
    endcase
    return r;
  endfunction

  // Drives one accepting edge and queues the expected result.
  task automatic launch(input logic [1:0]  o,
                        input logic [3:0]  c,
                        input logic [15:0] v,
                        input logic [15:0] e);
    start  = 1'b1;
    op     = o;
    count  = c;
    in_val = v;
    sb_q.push_back(e);
    tick();
    start = 1'b0;
  endtask

  task automatic await_done(input int exp_lat,
                            input string nm);
    int  lat;
    int  bcnt;
    bit  ok;
    lat  = 0;
    bcnt = 0;
    ok   = 1'b0;
    for (int k = 0; k < 40; k++) begin
      if (done) begin
        ok = 1'b1;
        break;
      end
      if (busy) bcnt++;
      lat++;
      tick();
    end
    if (!ok) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s timeout: no done in 40 cycles", nm);
      sb_q.delete();
    end else begin
      chk({nm, " latency"}, lat, exp_lat);
      chk({nm, " busy_cycles"}, bcnt, exp_lat);
      if (sb_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL %s: done with empty scoreboard", nm);
      end else begin
        last_exp = sb_q.pop_front();
        chk({nm, " result"}, result, last_exp);
      end
    end
  endtask

  task automatic run_op(input logic [1:0]  o,
                        input logic [3:0]  c,
                        input logic [15:0] v,
                        input logic [15:0] e,
                        input string       nm);
    launch(o, c, v, e);
    await_done(eff_n(o, c), nm);
    tick();
    chk({nm, " done_pulse"}, done, 0);
    chk({nm, " hold"}, result, last_exp);
  endtask

  initial begin
    vecs[0] = '{2'b01, 4'd4,  16'h0001, 16'h0010, "lsl1x4"};
    vecs[1] = '{2'b11, 4'd15, 16'h8000, 16'hFFFF, "asr15"};
    vecs[2] = '{2'b10, 4'd15, 16'h8000, 16'h0001, "lsr15"};
    vecs[3] = '{2'b01, 4'd0,  16'hA5A5, 16'hA5A5, "cnt0"};
    vecs[4] = '{2'b00, 4'd9,  16'hA5A5, 16'hA5A5, "opnone"};
    vecs[5] = '{2'b10, 4'd4,  16'h00F0, 16'h000F, "lsr4"};
    vecs[6] = '{2'b11, 4'd3,  16'h7FFF, 16'h0FFF, "asr_pos"};
    vecs[7] = '{2'b01, 4'd15, 16'hFFFF, 16'h8000, "lsl15"};
    vecs[8] = '{2'b11, 4'd1,  16'h8001, 16'hC000, "asr1"};
    vecs[9] = '{2'b01, 4'd1,  16'h8000, 16'h0000, "lsl_out"};

    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    chk("reset busy", busy, 0);
    chk("reset done", done, 0);
    chk("reset result", result, 16'h0000);

    foreach (vecs[i])
      run_op(vecs[i].op, vecs[i].cnt, vecs[i].val,
             vecs[i].exp, vecs[i].nm);

    // start mid-shift must be ignored
    launch(2'b01, 4'd6, 16'h0003, 16'h00C0);
    tick();
    tick();
    start  = 1'b1;
    op     = 2'b10;
    count  = 4'd1;
    in_val = 16'hFFFF;
    tick();
    start = 1'b0;
    await_done(3, "mid_start");
    tick();

    // back-to-back accept in the done cycle
    launch(2'b01, 4'd2, 16'h0001, 16'h0004);
    await_done(2, "b2b_first");
    launch(2'b10, 4'd3, 16'h8000, 16'h1000);
    await_done(3, "b2b_second");
    tick();
    chk("b2b done_pulse", done, 0);

    // reset on the 3rd shift of 8 abandons the op
    launch(2'b01, 4'd8, 16'h0001, 16'h0100);
    tick();
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    sb_q.delete();
    chk("rst_mid busy", busy, 0);
    chk("rst_mid done", done, 0);
    chk("rst_mid result", result, 16'h0000);
    begin
      logic seen;
      seen = 1'b0;
      for (int k = 0; k < 8; k++) begin
        tick();
        seen = seen | done | busy;
      end
      chk("rst_mid no_done", seen, 0);
    end
    run_op(2'b10, 4'd4, 16'h00F0, 16'h000F, "post_rst");

    for (int i = 0; i < 200; i++) begin
      logic [1:0]  ro;
      logic [3:0]  rc;
      logic [15:0] rv;
      ro = 2'($urandom_range(0, 3));
      rc = 4'($urandom_range(0, 15));
      rv = 16'($urandom);
      run_op(ro, rc, rv, model(ro, rc, rv), "rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
